// File: rtl/ltc220x_pkg.sv
// Shared types and default sizing for the LTC220x multi-channel capture block.
package ltc220x_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    localparam int unsigned DEF_NUM_CH     = 16;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 16;
    localparam int unsigned DEF_LEN_W      = 16;
    localparam int unsigned DEF_DEC_W      = 8;

endpackage

// File: rtl/ltc220x_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rd_data always shows the head entry.
module ltc220x_sync_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is accepted when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ltc220x_multi_capture.sv
// Captures decimated parallel ADC frames and serializes enabled channels
// into a stream of {last, chan, data} beats through an output FIFO.
module ltc220x_multi_capture
    import ltc220x_pkg::*;
#(
    parameter  int unsigned NUM_CH     = DEF_NUM_CH,
    parameter  int unsigned DATA_W     = DEF_DATA_W,
    parameter  int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter  int unsigned LEN_W      = DEF_LEN_W,
    parameter  int unsigned DEC_W      = DEF_DEC_W,
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [NUM_CH-1:0]        cfg_ch_en,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [DEC_W-1:0]         cfg_decim,
    input  logic                     cfg_twos,
    input  logic [NUM_CH*DATA_W-1:0] adc_data,
    input  logic                     adc_valid,
    output logic [DATA_W-1:0]        m_data,
    output logic [CH_W-1:0]          m_chan,
    output logic                     m_last,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);

    localparam int unsigned ENT_W = 1 + CH_W + DATA_W;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_t                   state;
    logic [NUM_CH-1:0]        ch_en_r;
    logic [LEN_W-1:0]         len_r;
    logic [DEC_W-1:0]         decim_r;
    logic                     twos_r;
    logic [DEC_W-1:0]         dec_cnt;
    logic [LEN_W-1:0]         frame_cnt;
    logic [NUM_CH*DATA_W-1:0] frame;
    logic [NUM_CH-1:0]        pending;
    logic                     frame_last;

    logic                     sel_found;
    logic [CH_W-1:0]          sel_chan;
    logic [DATA_W-1:0]        sel_data;
    logic [NUM_CH-1:0]        rest;
    logic                     push;
    logic                     push_last;
    logic [ENT_W-1:0]         push_word;
    logic [ENT_W-1:0]         pop_word;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [CNT_W-1:0]         fifo_count;
    logic [NUM_CH*DATA_W-1:0] conv;

    // Serializer: lowest pending channel goes out first, one per cycle.
    always_comb begin
        sel_found = 1'b0;
        sel_chan  = '0;
        sel_data  = '0;
        rest      = pending;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!sel_found && pending[k]) begin
                sel_found = 1'b1;
                sel_chan  = CH_W'(k);
                sel_data  = frame[k*DATA_W +: DATA_W];
                rest[k]   = 1'b0;
            end
        end
        push      = sel_found && !fifo_full;
        push_last = frame_last && (rest == '0);
        push_word = {push_last, sel_chan, sel_data};
    end

    // Offset-binary to two's complement is a per-channel MSB flip.
    always_comb begin
        conv = adc_data;
        if (twos_r) begin
            for (int k = 0; k < NUM_CH; k++) begin
                conv[k*DATA_W + DATA_W - 1] = ~adc_data[k*DATA_W + DATA_W - 1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            ch_en_r    <= '0;
            len_r      <= '0;
            decim_r    <= '0;
            twos_r     <= 1'b0;
            dec_cnt    <= '0;
            frame_cnt  <= '0;
            frame      <= '0;
            pending    <= '0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else if (abort) begin
            state      <= ST_IDLE;
            pending    <= '0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (push) begin
                pending <= rest;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start && (cfg_ch_en != '0) && (cfg_len != '0)) begin
                        ch_en_r    <= cfg_ch_en;
                        len_r      <= cfg_len;
                        decim_r    <= cfg_decim;
                        twos_r     <= cfg_twos;
                        dec_cnt    <= '0;
                        frame_cnt  <= '0;
                        frame_last <= 1'b0;
                        overflow   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (adc_valid) begin
                        if (dec_cnt == decim_r) begin
                            dec_cnt <= '0;
                            // Serializer still busy: the kept frame is lost.
                            if (pending != '0) begin
                                overflow <= 1'b1;
                            end else begin
                                frame      <= conv;
                                pending    <= ch_en_r;
                                frame_cnt  <= frame_cnt + LEN_W'(1);
                                frame_last <= ((frame_cnt + LEN_W'(1)) == len_r);
                                if ((frame_cnt + LEN_W'(1)) == len_r) begin
                                    state <= ST_DRAIN;
                                end
                            end
                        end else begin
                            dec_cnt <= dec_cnt + DEC_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if ((pending == '0) && (fifo_count == '0)) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ltc220x_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (abort),
        .push    (push),
        .wr_data (push_word),
        .pop     (m_ready),
        .rd_data (pop_word),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign m_valid                  = !fifo_empty;
    assign {m_last, m_chan, m_data} = pop_word;

endmodule

// File: doc/ltc220x_multi_capture.md
LTC220X_MULTI_CAPTURE -- requirements
Module: ltc220x_multi_capture

Interface
REQ-001 Parameter NUM_CH, default 16: number of ADC channels captured in parallel.
REQ-002 Parameter DATA_W, default 16: bits per ADC sample.
REQ-003 Parameter FIFO_DEPTH, default 16: output FIFO entries, power of two, at least 4.
REQ-004 Parameter LEN_W, default 16: width of frame counter and cfg_len.
REQ-005 Parameter DEC_W, default 8: width of decimation counter and cfg_decim.
REQ-006 The ports SHALL be, in order:
  clk  in  1  single clock for all logic.
  reset  in  1  synchronous, active-high reset.
  start  in  1  one-cycle pulse; begins a capture.
  abort  in  1  one-cycle pulse; cancels a capture.
  cfg_ch_en  in  NUM_CH  per-channel enable mask.
  cfg_len  in  LEN_W  frames to capture.
  cfg_decim  in  DEC_W  keep 1 of every cfg_decim+1 conversions.
  cfg_twos  in  1  1 = convert offset-binary to two's complement.
  adc_data  in  NUM_CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
  adc_valid  in  1  one-cycle strobe: adc_data holds a new conversion.
  m_data  out  DATA_W  output sample.
  m_chan  out  clog2(NUM_CH)  channel index of m_data.
  m_last  out  1  last sample of the capture.
  m_valid  out  1  output valid.
  m_ready  in  1  downstream ready.
  busy  out  1  state is not IDLE.
  done  out  1  one-cycle pulse at normal completion.
  overflow  out  1  sticky; a kept frame was dropped.

Function
REQ-007 FSM states SHALL be IDLE, CAPTURE and DRAIN.
REQ-008 IDLE->CAPTURE SHALL occur on start only if cfg_ch_en!=0 and cfg_len!=0; otherwise start SHALL be ignored.
REQ-009 cfg_* SHALL be registered on the accepted start and SHALL be ignored until the next capture.
REQ-010 In CAPTURE, each adc_valid SHALL advance a decimation counter that resets to 0 on start.
REQ-011 A conversion SHALL be kept when the counter equals cfg_decim, after which the counter returns to 0.
REQ-012 A kept conversion SHALL latch all channels into a frame register, with MSB inverted per channel when cfg_twos=1.
REQ-013 The serializer SHALL push enabled channels only, in ascending index order, one per cycle, into the FIFO.
REQ-014 The serializer SHALL stall while the FIFO is full.
REQ-015 A kept conversion arriving while the serializer is still busy SHALL be dropped, SHALL set overflow, and SHALL NOT count as a frame.
REQ-016 Latency SHALL be: adc_valid at cycle t for a kept frame gives first FIFO write at t+1, and m_valid at t+2 when the FIFO was empty.
REQ-017 The frame counter SHALL increment per latched frame; on reaching cfg_len, CAPTURE->DRAIN and further adc_valid SHALL be ignored.
REQ-018 DRAIN->IDLE SHALL occur once the serializer is idle and the FIFO is empty; done SHALL pulse in that same cycle.
REQ-019 m_last SHALL be 1 only on the highest enabled channel of frame cfg_len.
REQ-020 m_data, m_chan and m_last SHALL be stable while m_valid=1 and m_ready=0.
REQ-021 A transfer SHALL occur when m_valid and m_ready are both 1.
REQ-022 A simultaneous FIFO push and pop when full SHALL be allowed and SHALL keep the count unchanged.
REQ-023 abort in any state SHALL flush the FIFO and serializer and go to IDLE with no done pulse.
REQ-024 abort SHALL take priority over a simultaneous start.
REQ-025 overflow SHALL clear only on reset or on an accepted start.
REQ-026 start while busy SHALL be ignored.

Reset
REQ-027 On reset, state SHALL be IDLE.
REQ-028 On reset, FIFO, counters, frame register and configuration registers SHALL clear to 0.
REQ-029 On reset, m_valid, m_last, busy, done and overflow SHALL be 0, and m_data and m_chan SHALL be 0.
REQ-030 Reset asserted mid-capture SHALL discard all data with no done pulse.

Structure
REQ-031 Package ltc220x_pkg SHALL hold the FSM state enum and the parameter default constants.
REQ-032 The FIFO SHALL be sub-module ltc220x_sync_fifo, with parameters for width and depth, and with full, empty and count outputs, first-word-fall-through.
REQ-033 The FIFO entry SHALL be {m_last, m_chan, m_data}.

Verification
REQ-034 NUM_CH=4, cfg_ch_en=4'b1111, cfg_len=2, cfg_decim=0, cfg_twos=0, m_ready=1, two adc_valid 10 cycles apart -> 8 beats, chan 0..3 twice, m_last on beat 8, done pulse, overflow=0.
REQ-035 cfg_ch_en=4'b1010, cfg_twos=1, channel data 16'h8000 -> m_chan 1 then 3, m_data 16'h0000 each.
REQ-036 cfg_decim=2, cfg_len=1, three adc_valid -> only the third conversion is output.
REQ-037 cfg_ch_en=4'b1111, adc_valid on two consecutive cycles -> second frame dropped, overflow=1, frame count not advanced.
REQ-038 FIFO_DEPTH=4, m_ready=0 for 20 cycles then 1 -> no data loss, outputs held stable while stalled, order preserved.
REQ-039 abort mid-CAPTURE with FIFO non-empty -> m_valid=0 next cycle, busy=0, no done pulse; a new start then succeeds.
